fpadd_special_out: RTL



---
 rtl/fpadd_special_out_pkg.sv | 40 ++++
 rtl/fpadd_special_out_sel.sv | 46 ++++
 rtl/fpadd_special_out.sv | 115 +++++++++++
 3 files changed

// File: rtl/fpadd_special_out_pkg.sv
// Shared format constants and special-result selection helpers for the FP
// adder special path. Format is single precision.
package fpadd_special_out_pkg;

  localparam int WIDTH = 32;
  localparam int WSIG  = 23;
  localparam int WEXP  = WIDTH - 1 - WSIG;

  // Significand MSB: set to quiet a NaN.
  localparam logic [WIDTH-1:0] QUIET_BIT = {{(WIDTH-WSIG){1'b0}}, 1'b1, {(WSIG-1){1'b0}}};

  // Default quiet NaN, also used by the adder normal path.
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {WEXP{1'b1}}, 1'b1, {(WSIG-1){1'b0}}};

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ANAN,
    SEL_BNAN,
    SEL_DNAN,
    SEL_AINF,
    SEL_BINF
  } sel_t;

  // Priority pick of which special result applies.
  function automatic sel_t pick_special(
    input logic anan,
    input logic bnan,
    input logic ainf,
    input logic binf,
    input logic sign_diff
  );
    if (anan)                          return SEL_ANAN;
    else if (bnan)                     return SEL_BNAN;
    else if (ainf && binf && sign_diff) return SEL_DNAN;
    else if (ainf)                     return SEL_AINF;
    else if (binf)                     return SEL_BINF;
    else                               return SEL_NONE;
  endfunction

endpackage

// File: rtl/fpadd_special_out_sel.sv
// Combinational special-result select: NaN propagation, inf-inf default NaN,
// signed infinity, and invalid-operation detection. Shared with the multiplier.
module fpadd_special_sel
  import fpadd_special_out_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             ainf,
  input  logic             binf,
  input  logic             anan,
  input  logic             bnan,
  input  logic             asignan,
  input  logic             bsignan,
  input  logic             specinput,
  output logic [WIDTH-1:0] result,
  output logic             result_special,
  output logic             invalid
);

  logic sb;
  sel_t sel;

  // b's sign as seen by the adder after the add/sub inversion.
  assign sb  = b[WIDTH-1] ^ op_sub;
  assign sel = pick_special(anan, bnan, ainf, binf, a[WIDTH-1] != sb);

  // Build the selected pattern; forced to zero when not a special case so the
  // output is clean for the normal-path mux.
  always_comb begin
    result = '0;
    unique case (sel)
      SEL_ANAN: result = a | QUIET_BIT;
      SEL_BNAN: result = b | QUIET_BIT;
      SEL_DNAN: result = QNAN;
      SEL_AINF: result = a;
      SEL_BINF: result = {sb, {WEXP{1'b1}}, {WSIG{1'b0}}};
      default:  result = '0;
    endcase
    if (!specinput) result = '0;
  end

  assign invalid        = asignan | bsignan | (sel == SEL_DNAN);
  assign result_special = specinput;

endmodule

// File: rtl/fpadd_special_out.sv
// Two-stage valid/ready pipeline around the special-result select, with a
// sticky invalid flag and a saturating count of special results delivered.
module fpadd_special_out
  import fpadd_special_out_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             ainf,
  input  logic             binf,
  input  logic             anan,
  input  logic             bnan,
  input  logic             asignan,
  input  logic             bsignan,
  input  logic             specinput,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_special,
  output logic             invalid,
  input  logic             clear_sticky,
  output logic             sticky_invalid,
  output logic [7:0]       spec_count
);

  logic [WIDTH-1:0] sel_result;
  logic             sel_special;
  logic             sel_invalid;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic             s1_special;
  logic             s1_invalid;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_special;
  logic             s2_invalid;

  logic             s2_load;
  logic             xfer;

  fpadd_special_sel u_sel (
    .a              (a),
    .b              (b),
    .op_sub         (op_sub),
    .ainf           (ainf),
    .binf           (binf),
    .anan           (anan),
    .bnan           (bnan),
    .asignan        (asignan),
    .bsignan        (bsignan),
    .specinput      (specinput),
    .result         (sel_result),
    .result_special (sel_special),
    .invalid        (sel_invalid)
  );

  assign s2_load  = ~s2_valid | out_ready;
  assign in_ready = ~s1_valid | ~s2_valid | out_ready;
  assign xfer     = s2_valid & out_ready;

  // Stage 1: capture the selected result; bubbles load zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_result  <= '0;
      s1_special <= 1'b0;
      s1_invalid <= 1'b0;
    end else if (in_ready) begin
      s1_valid   <= in_valid;
      s1_result  <= in_valid ? sel_result : '0;
      s1_special <= in_valid & sel_special;
      s1_invalid <= in_valid & sel_invalid;
    end
  end

  // Stage 2: output register, holds while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_special <= 1'b0;
      s2_invalid <= 1'b0;
    end else if (s2_load) begin
      s2_valid   <= s1_valid;
      s2_result  <= s1_valid ? s1_result : '0;
      s2_special <= s1_valid & s1_special;
      s2_invalid <= s1_valid & s1_invalid;
    end
  end

  assign out_valid      = s2_valid;
  assign result         = s2_result;
  assign result_special = s2_special;
  assign invalid        = s2_invalid;

  // Sticky invalid: a set on a transfer beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  sticky_invalid <= 1'b0;
    else if (xfer & s2_invalid) sticky_invalid <= 1'b1;
    else if (clear_sticky)      sticky_invalid <= 1'b0;
  end

  // Saturating count of special results handed downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          spec_count <= 8'd0;
    else if (xfer && s2_special && spec_count != 8'hFF) spec_count <= spec_count + 8'd1;
  end

endmodule
